// File: rtl/nonce_tx_scheduler_pkg.sv
// Shared constants and FSM encoding for the nonce transmit scheduler.
// Imported by the interface, the arbiter and the top.
package nonce_tx_scheduler_pkg;

    localparam int unsigned NONCE_W         = 32;
    localparam int unsigned BYTE_W          = 8;
    localparam int unsigned BYTES_PER_NONCE = NONCE_W / BYTE_W;
    localparam int unsigned TIMEOUT_DEFAULT = 65535;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GUARD,
        S_WAITB
    } state_e;

    function automatic logic [BYTE_W-1:0] msb_byte(input logic [NONCE_W-1:0] v);
        return v[NONCE_W-1 -: BYTE_W];
    endfunction

endpackage

// File: rtl/nonce_tx_scheduler_if.sv
// Byte-wide start/busy handshake between the scheduler (master) and the UART transmitter.
interface nonce_tx_scheduler_if;
    import nonce_tx_scheduler_pkg::*;

    logic [BYTE_W-1:0] tx_data;
    logic              tx_start;
    logic              tx_busy;

    modport master (
        output tx_data,
        output tx_start,
        input  tx_busy
    );

    modport slave (
        input  tx_data,
        input  tx_start,
        output tx_busy
    );

endinterface

// File: rtl/nonce_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past last_grant and wraps.
module nonce_tx_scheduler_rr_arbiter #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned SRC_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SRC_W-1:0]   last_grant,
    output logic [NUM_SRC-1:0] grant_onehot,
    output logic [SRC_W-1:0]   grant_idx,
    output logic               any_req
);

    always_comb begin
        int unsigned      cand;
        logic [SRC_W-1:0] idx;
        grant_onehot = '0;
        grant_idx    = '0;
        any_req      = 1'b0;
        cand         = 0;
        idx          = '0;
        for (int unsigned off = 1; off <= NUM_SRC; off++) begin
            cand = (32'(last_grant) + off) % NUM_SRC;
            idx  = SRC_W'(cand);
            if (!any_req && req[idx]) begin
                any_req           = 1'b1;
                grant_idx         = idx;
                grant_onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nonce_tx_scheduler.sv
// Collects nonces from NUM_SRC sources into single-entry holding registers and sends
// each one MSB first over a byte-wide start/busy transmitter, with a busy watchdog.
module nonce_tx_scheduler
    import nonce_tx_scheduler_pkg::*;
#(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned SRC_W   = $clog2(NUM_SRC),
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NONCE_W*NUM_SRC-1:0] nonce_in,
    input  logic [NUM_SRC-1:0]         nonce_valid,
    nonce_tx_scheduler_if.master       tx,
    output logic [SRC_W-1:0]           grant_src,
    output logic                       frame_active,
    output logic [NUM_SRC-1:0]         overflow,
    output logic                       timeout_err
);

    localparam int unsigned CNT_W = $clog2(BYTES_PER_NONCE);
    localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_NONCE - 1);
    localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT - 1);

    state_e                state_q, state_d;
    logic [NONCE_W-1:0]    hold_q [NUM_SRC];
    logic [NONCE_W-1:0]    hold_d [NUM_SRC];
    logic [NUM_SRC-1:0]    pending_q, pending_d;
    logic [NUM_SRC-1:0]    overflow_q, overflow_d;
    logic [NONCE_W-1:0]    shift_q, shift_d;
    logic [SRC_W-1:0]      grant_q, grant_d;
    logic [SRC_W-1:0]      last_grant_q, last_grant_d;
    logic [CNT_W-1:0]      byte_cnt_q, byte_cnt_d;
    logic [WD_W-1:0]       wd_q, wd_d;
    logic                  frame_active_q, frame_active_d;
    logic                  timeout_err_q, timeout_err_d;
    logic                  tx_start_q, tx_start_d;
    logic [BYTE_W-1:0]     tx_data_q, tx_data_d;

    logic [NUM_SRC-1:0]    win_onehot;
    logic [SRC_W-1:0]      win_idx;
    logic                  any_pending;
    logic [NUM_SRC-1:0]    grant_clear;

    // Arbitration sees only registered pending flags, so a fresh capture waits a cycle.
    nonce_tx_scheduler_rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .SRC_W   (SRC_W)
    ) u_rr_arbiter (
        .req          (pending_q),
        .last_grant   (last_grant_q),
        .grant_onehot (win_onehot),
        .grant_idx    (win_idx),
        .any_req      (any_pending)
    );

    assign grant_clear = (state_q == S_IDLE) ? win_onehot : '0;

    always_comb begin
        hold_d     = hold_q;
        pending_d  = pending_q;
        overflow_d = overflow_q;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (grant_clear[i]) begin
                pending_d[i] = 1'b0;
            end
            if (nonce_valid[i]) begin
                hold_d[i]    = nonce_in[i*NONCE_W +: NONCE_W];
                pending_d[i] = 1'b1;
                if (pending_q[i] && !grant_clear[i]) begin
                    overflow_d[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        shift_d        = shift_q;
        grant_d        = grant_q;
        last_grant_d   = last_grant_q;
        byte_cnt_d     = byte_cnt_q;
        wd_d           = wd_q;
        frame_active_d = frame_active_q;
        timeout_err_d  = timeout_err_q;
        tx_start_d     = 1'b0;
        tx_data_d      = tx_data_q;
        unique case (state_q)
            S_IDLE: begin
                if (any_pending) begin
                    shift_d        = hold_q[win_idx];
                    grant_d        = win_idx;
                    byte_cnt_d     = '0;
                    frame_active_d = 1'b1;
                    state_d        = S_SEND;
                end
            end
            S_SEND: begin
                if (!tx.tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = msb_byte(shift_q);
                    state_d    = S_GUARD;
                end
            end
            S_GUARD: begin
                // Transmitter raises busy a cycle after the strobe; do not sample it here.
                wd_d    = '0;
                state_d = S_WAITB;
            end
            S_WAITB: begin
                if (!tx.tx_busy) begin
                    if (byte_cnt_q == LAST_BYTE) begin
                        last_grant_d   = grant_q;
                        frame_active_d = 1'b0;
                        state_d        = S_IDLE;
                    end else begin
                        shift_d    = {shift_q[NONCE_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        state_d    = S_SEND;
                    end
                end else if (wd_q == WD_LAST) begin
                    timeout_err_d  = 1'b1;
                    frame_active_d = 1'b0;
                    last_grant_d   = grant_q;
                    state_d        = S_IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            for (int i = 0; i < int'(NUM_SRC); i++) begin
                hold_q[i] <= '0;
            end
            pending_q      <= '0;
            overflow_q     <= '0;
            shift_q        <= '0;
            grant_q        <= '0;
            last_grant_q   <= SRC_W'(NUM_SRC - 1);
            byte_cnt_q     <= '0;
            wd_q           <= '0;
            frame_active_q <= 1'b0;
            timeout_err_q  <= 1'b0;
            tx_start_q     <= 1'b0;
            tx_data_q      <= '0;
        end else begin
            state_q        <= state_d;
            hold_q         <= hold_d;
            pending_q      <= pending_d;
            overflow_q     <= overflow_d;
            shift_q        <= shift_d;
            grant_q        <= grant_d;
            last_grant_q   <= last_grant_d;
            byte_cnt_q     <= byte_cnt_d;
            wd_q           <= wd_d;
            frame_active_q <= frame_active_d;
            timeout_err_q  <= timeout_err_d;
            tx_start_q     <= tx_start_d;
            tx_data_q      <= tx_data_d;
        end
    end

    assign tx.tx_start   = tx_start_q;
    assign tx.tx_data    = tx_data_q;
    assign grant_src     = grant_q;
    assign frame_active  = frame_active_q;
    assign overflow      = overflow_q;
    assign timeout_err   = timeout_err_q;

endmodule
